// File: rtl/mem_xfer_pkg.sv
// Shared types and default sizes for the memory-to-memory transfer path.
package mem_xfer_pkg;

    // Write-side controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ADDR_W_DEF = 3;
    localparam int unsigned DEPTH_DEF  = 8;

endpackage : mem_xfer_pkg

// File: rtl/addr_counter_b.sv
// Memory-B write pointer: up-counter wrapping modulo 2**ADDR_W.
module addr_counter_b #(
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clock,
    input  logic              Reset,
    input  logic              Clear,
    input  logic              Inc,
    output logic [ADDR_W-1:0] Count
);

    logic [ADDR_W-1:0] r_count;

    // Reset and Clear both return the pointer to address 0; Inc wraps naturally
    always_ff @(posedge clock) begin
        if (Reset || Clear) begin
            r_count <= '0;
        end else if (Inc) begin
            r_count <= r_count + ADDR_W'(1);
        end
    end

    assign Count = r_count;

endmodule : addr_counter_b

// File: rtl/mem_b_write_ctrl.sv
// Write-side controller: accepts words from memory A and fills memory B from address 0.
module mem_b_write_ctrl
    import mem_xfer_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic              clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Abort,
    input  logic [DATA_W-1:0] DataIn,
    input  logic              DataValid,
    output logic              DataReady,
    output logic [ADDR_W-1:0] AddrB,
    output logic [DATA_W-1:0] DataOutB,
    output logic              WEB,
    output logic              Busy,
    output logic              Done,
    output logic [ADDR_W:0]   WordCount
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_ready;
    logic               w_accept;
    logic               w_clear;
    logic [ADDR_W-1:0]  w_ptr;
    logic [ADDR_W-1:0]  r_addr_b;
    logic [DATA_W-1:0]  r_data_out_b;
    logic               r_web;
    logic [CNT_W-1:0]   r_word_count;

    addr_counter_b #(
        .ADDR_W (ADDR_W)
    ) u_addr_counter_b (
        .clock (clock),
        .Reset (Reset),
        .Clear (w_clear),
        .Inc   (w_accept),
        .Count (w_ptr)
    );

    // State register
    always_ff @(posedge clock) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, handshake and pointer-control decode; Abort masks acceptance
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_accept    = 1'b0;
        w_clear     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (Start) begin
                    w_state_nxt = RUN;
                    w_clear     = 1'b1;
                end
            end
            RUN: begin
                w_ready  = !Abort && (r_word_count < CNT_W'(DEPTH));
                w_accept = DataValid && w_ready;
                if (Abort) begin
                    w_state_nxt = IDLE;
                end else if (w_accept && (r_word_count == CNT_W'(DEPTH - 1))) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Write-port and word-count registers; address/data hold when nothing is accepted
    always_ff @(posedge clock) begin
        if (Reset) begin
            r_addr_b     <= '0;
            r_data_out_b <= '0;
            r_web        <= 1'b0;
            r_word_count <= '0;
        end else begin
            r_web <= w_accept;
            if (w_accept) begin
                r_addr_b     <= w_ptr;
                r_data_out_b <= DataIn;
            end
            if (w_clear) begin
                r_word_count <= '0;
            end else if (w_accept) begin
                r_word_count <= r_word_count + CNT_W'(1);
            end
        end
    end

    assign DataReady = w_ready;
    assign AddrB     = r_addr_b;
    assign DataOutB  = r_data_out_b;
    assign WEB       = r_web;
    assign WordCount = r_word_count;
    assign Busy      = (r_state == RUN);
    assign Done      = (r_state == DONE);

endmodule : mem_b_write_ctrl

// File: tb/tb_mem_b_write_ctrl.sv
// Directed self-checking bench for mem_b_write_ctrl (DATA_W=8, ADDR_W=3, DEPTH=8).
module tb_mem_b_write_ctrl;

    logic       clock;
    logic       Reset;
    logic       Start;
    logic       Abort;
    logic [7:0] DataIn;
    logic       DataValid;
    logic       DataReady;
    logic [2:0] AddrB;
    logic [7:0] DataOutB;
    logic       WEB;
    logic       Busy;
    logic       Done;
    logic [3:0] WordCount;

    int errors = 0;
    int checks = 0;

    mem_b_write_ctrl #(
        .DATA_W (8),
        .ADDR_W (3),
        .DEPTH  (8)
    ) dut (
        .clock     (clock),
        .Reset     (Reset),
        .Start     (Start),
        .Abort     (Abort),
        .DataIn    (DataIn),
        .DataValid (DataValid),
        .DataReady (DataReady),
        .AddrB     (AddrB),
        .DataOutB  (DataOutB),
        .WEB       (WEB),
        .Busy      (Busy),
        .Done      (Done),
        .WordCount (WordCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick();
        tick();
        checks++; if (AddrB !== 3'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", AddrB); end
        checks++; if (WEB !== 1'b0) begin errors++; $display("FAIL reset_web: got %b want 0", WEB); end
        checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", Done); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
        checks++; if (WordCount !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", WordCount); end
        checks++; if (DataReady !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", DataReady); end
        checks++; if (DataOutB !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", DataOutB); end
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_stream();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL stream_busy_start: got %b want 1", Busy); end
        checks++; if (DataReady !== 1'b1) begin errors++; $display("FAIL stream_ready_start: got %b want 1", DataReady); end
        for (int i = 0; i < 8; i++) begin
            DataValid = 1'b1;
            DataIn    = 8'(8'hA0 + i);
            tick();
            checks++; if (WEB !== 1'b1) begin errors++; $display("FAIL stream_web[%0d]: got %b want 1", i, WEB); end
            checks++; if (AddrB !== 3'(i)) begin errors++; $display("FAIL stream_addr[%0d]: got %0d want %0d", i, AddrB, i); end
            checks++; if (DataOutB !== 8'(8'hA0 + i)) begin errors++; $display("FAIL stream_data[%0d]: got %h want %h", i, DataOutB, 8'(8'hA0 + i)); end
            checks++; if (Done !== (i == 7)) begin errors++; $display("FAIL stream_done[%0d]: got %b want %b", i, Done, (i == 7)); end
            checks++; if (Busy !== (i != 7)) begin errors++; $display("FAIL stream_busy[%0d]: got %b want %b", i, Busy, (i != 7)); end
        end
        DataValid = 1'b0;
        tick();
        checks++; if (WEB !== 1'b0) begin errors++; $display("FAIL stream_web_end: got %b want 0", WEB); end
        checks++; if (Done !== 1'b0) begin errors++; $display("FAIL stream_done_end: got %b want 0", Done); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL stream_busy_end: got %b want 0", Busy); end
        checks++; if (WordCount !== 4'd8) begin errors++; $display("FAIL stream_count: got %0d want 8", WordCount); end
        checks++; if (AddrB !== 3'd7) begin errors++; $display("FAIL stream_addr_hold: got %0d want 7", AddrB); end
    endtask

    task automatic test_toggle();
        int n_writes;
        n_writes = 0;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int c = 0; c < 16; c++) begin
            DataValid = (c % 2 == 0);
            DataIn    = 8'(8'h50 + c / 2);
            tick();
            if (WEB === 1'b1) n_writes++;
            if (c % 2 == 0) begin
                checks++; if (WEB !== 1'b1) begin errors++; $display("FAIL toggle_web[%0d]: got %b want 1", c, WEB); end
                checks++; if (AddrB !== 3'(c / 2)) begin errors++; $display("FAIL toggle_addr[%0d]: got %0d want %0d", c, AddrB, c / 2); end
                checks++; if (DataOutB !== 8'(8'h50 + c / 2)) begin errors++; $display("FAIL toggle_data[%0d]: got %h want %h", c, DataOutB, 8'(8'h50 + c / 2)); end
                checks++; if (Done !== (c == 14)) begin errors++; $display("FAIL toggle_done[%0d]: got %b want %b", c, Done, (c == 14)); end
            end else begin
                checks++; if (WEB !== 1'b0) begin errors++; $display("FAIL toggle_idle_web[%0d]: got %b want 0", c, WEB); end
            end
        end
        DataValid = 1'b0;
        checks++; if (n_writes != 8) begin errors++; $display("FAIL toggle_writes: got %0d want 8", n_writes); end
        checks++; if (WordCount !== 4'd8) begin errors++; $display("FAIL toggle_count: got %0d want 8", WordCount); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL toggle_busy: got %b want 0", Busy); end
    endtask

    task automatic test_abort();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            DataValid = 1'b1;
            DataIn    = 8'(8'hC0 + i);
            tick();
        end
        checks++; if (WEB !== 1'b1) begin errors++; $display("FAIL abort_web_pre: got %b want 1", WEB); end
        checks++; if (AddrB !== 3'd2) begin errors++; $display("FAIL abort_addr_pre: got %0d want 2", AddrB); end
        Abort  = 1'b1;
        DataIn = 8'hEE;
        #1;
        checks++; if (DataReady !== 1'b0) begin errors++; $display("FAIL abort_ready: got %b want 0", DataReady); end
        tick();
        Abort     = 1'b0;
        DataValid = 1'b0;
        checks++; if (WEB !== 1'b0) begin errors++; $display("FAIL abort_web: got %b want 0", WEB); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", Busy); end
        checks++; if (Done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b want 0", Done); end
        checks++; if (WordCount !== 4'd3) begin errors++; $display("FAIL abort_count: got %0d want 3", WordCount); end
        checks++; if (AddrB !== 3'd2) begin errors++; $display("FAIL abort_addr: got %0d want 2", AddrB); end
        checks++; if (DataOutB !== 8'hC2) begin errors++; $display("FAIL abort_data: got %h want c2", DataOutB); end
        tick();
        checks++; if (WordCount !== 4'd3) begin errors++; $display("FAIL abort_count_hold: got %0d want 3", WordCount); end
        checks++; if (Done !== 1'b0) begin errors++; $display("FAIL abort_done_hold: got %b want 0", Done); end
    endtask

    task automatic test_reset_mid();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            DataValid = 1'b1;
            DataIn    = 8'(8'hB0 + i);
            tick();
        end
        checks++; if (WEB !== 1'b1) begin errors++; $display("FAIL rmid_web_pre: got %b want 1", WEB); end
        checks++; if (AddrB !== 3'd4) begin errors++; $display("FAIL rmid_addr_pre: got %0d want 4", AddrB); end
        Reset  = 1'b1;
        DataIn = 8'hFF;
        tick();
        Reset     = 1'b0;
        DataValid = 1'b0;
        checks++; if (WEB !== 1'b0) begin errors++; $display("FAIL rmid_web: got %b want 0", WEB); end
        checks++; if (AddrB !== 3'd0) begin errors++; $display("FAIL rmid_addr: got %0d want 0", AddrB); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", Busy); end
        checks++; if (Done !== 1'b0) begin errors++; $display("FAIL rmid_done: got %b want 0", Done); end
        checks++; if (WordCount !== 4'd0) begin errors++; $display("FAIL rmid_count: got %0d want 0", WordCount); end
        Start = 1'b1;
        tick();
        Start = 1'b0;
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL rmid_restart_busy: got %b want 1", Busy); end
        DataValid = 1'b1;
        DataIn    = 8'h77;
        tick();
        DataValid = 1'b0;
        checks++; if (WEB !== 1'b1) begin errors++; $display("FAIL rmid_restart_web: got %b want 1", WEB); end
        checks++; if (AddrB !== 3'd0) begin errors++; $display("FAIL rmid_restart_addr: got %0d want 0", AddrB); end
        checks++; if (DataOutB !== 8'h77) begin errors++; $display("FAIL rmid_restart_data: got %h want 77", DataOutB); end
        checks++; if (WordCount !== 4'd1) begin errors++; $display("FAIL rmid_restart_count: got %0d want 1", WordCount); end
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_start_ignored();
        Start = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            Start     = (i == 2 || i == 5);
            DataValid = 1'b1;
            DataIn    = 8'(8'h30 + i);
            tick();
            checks++; if (WEB !== 1'b1) begin errors++; $display("FAIL sign_web[%0d]: got %b want 1", i, WEB); end
            checks++; if (AddrB !== 3'(i)) begin errors++; $display("FAIL sign_addr[%0d]: got %0d want %0d", i, AddrB, i); end
            checks++; if (DataOutB !== 8'(8'h30 + i)) begin errors++; $display("FAIL sign_data[%0d]: got %h want %h", i, DataOutB, 8'(8'h30 + i)); end
            checks++; if (WordCount !== 4'(i + 1)) begin errors++; $display("FAIL sign_count[%0d]: got %0d want %0d", i, WordCount, i + 1); end
            checks++; if (Done !== (i == 7)) begin errors++; $display("FAIL sign_done[%0d]: got %b want %b", i, Done, (i == 7)); end
        end
        Start     = 1'b0;
        DataValid = 1'b0;
        tick();
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL sign_busy_end: got %b want 0", Busy); end
        checks++; if (WordCount !== 4'd8) begin errors++; $display("FAIL sign_count_end: got %0d want 8", WordCount); end
        tick();
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL sign_busy_idle: got %b want 0", Busy); end
    endtask

    initial begin
        Reset     = 1'b1;
        Start     = 1'b0;
        Abort     = 1'b0;
        DataIn    = 8'h00;
        DataValid = 1'b0;
        @(negedge clock);
        test_reset();
        test_stream();
        test_toggle();
        test_abort();
        test_reset_mid();
        test_start_ignored();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mem_b_write_ctrl
